// File: rtl/hls_deadlock_axis_monitor.sv
// Deadlock monitor: flags a persistent AXIS/child stall while at least one instance is busy.
// Define HLS_DEADLOCK_MON_CAPTURE_EN to capture the first offending channel and count blocked cycles.
module hls_deadlock_axis_monitor #(
   parameter int NUM_AXIS = 5,
   parameter int NUM_SUB  = 1,
   parameter int NUM_INST = 4,
   parameter int THRESH   = 16,
   parameter int CNT_W    = 16,
   localparam int CHAN_W  = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic [NUM_AXIS-1:0] axis_mask,
   input  logic [NUM_SUB-1:0]  sub_block_sigs,
   input  logic [NUM_INST-1:0] inst_idle_sigs,
   input  logic                clear,
   output logic                block,
   output logic [CHAN_W-1:0]   first_chan,
   output logic [CNT_W-1:0]    block_cycles
);

   typedef enum logic [1:0] {
      IDLE,
      SUSPECT,
      BLOCKED
   } state_t;

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  persist_q, persist_d;
   logic              block_q;
   logic [NUM_AXIS-1:0] axisHits;
   logic              cond;

   assign axisHits = axis_block_sigs & axis_mask;
   assign cond     = (|axisHits | |sub_block_sigs) & ~(&inst_idle_sigs);

   // Persistence filter: cond must hold for THRESH consecutive edges before BLOCKED.
   always_comb begin
      state_d   = state_q;
      persist_d = persist_q;
      if (clear) begin
         state_d   = IDLE;
         persist_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cond) begin
                  if (THRESH == 1) begin
                     state_d   = BLOCKED;
                     persist_d = '0;
                  end else begin
                     state_d   = SUSPECT;
                     persist_d = CNT_W'(1);
                  end
               end
            end
            SUSPECT: begin
               if (!cond) begin
                  state_d   = IDLE;
                  persist_d = '0;
               end else if (persist_q + CNT_W'(1) == THRESH_C) begin
                  state_d   = BLOCKED;
                  persist_d = '0;
               end else begin
                  persist_d = persist_q + CNT_W'(1);
               end
            end
            BLOCKED: begin
               if (!cond) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d   = IDLE;
               persist_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         persist_q <= '0;
         block_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         persist_q <= persist_d;
         block_q   <= (state_d == BLOCKED);
      end
   end

   assign block = block_q;

`ifdef HLS_DEADLOCK_MON_CAPTURE_EN
   logic [CHAN_W-1:0] firstChan_q, firstChan_d, lowIdx;
   logic [CNT_W-1:0]  cycles_q, cycles_d;

   // Highest index scanned first so the lowest set index wins.
   always_comb begin
      lowIdx = '0;
      for (int i = NUM_AXIS - 1; i >= 0; i--) begin
         if (axisHits[i]) begin
            lowIdx = CHAN_W'(i);
         end
      end
   end

   // Capture only on BLOCKED entry; the duration counter saturates instead of wrapping.
   always_comb begin
      firstChan_d = firstChan_q;
      cycles_d    = '0;
      if (state_d == BLOCKED) begin
         if (state_q != BLOCKED) begin
            firstChan_d = lowIdx;
            cycles_d    = CNT_W'(1);
         end else begin
            cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
         end
      end else if (clear) begin
         firstChan_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         firstChan_q <= '0;
         cycles_q    <= '0;
      end else begin
         firstChan_q <= firstChan_d;
         cycles_q    <= cycles_d;
      end
   end

   assign first_chan   = firstChan_q;
   assign block_cycles = cycles_q;
`else
   assign first_chan   = '0;
   assign block_cycles = '0;
`endif

endmodule
